// File: rtl/filter_loader_pkg.sv
// Shared constants, state type and helpers for the filter loader that feeds filter_buffer.
package filter_loader_pkg;

    localparam int FL_WID_FILTER = 16;
    localparam int FL_NUM_TAPS   = 9;
    localparam int FL_CNT_W      = 4;

    typedef enum logic [1:0] {
        FL_IDLE = 2'd0,
        FL_WAIT = 2'd1,
        FL_LOAD = 2'd2,
        FL_HOLD = 2'd3
    } fl_state_t;

    function automatic logic tapsFull(input logic [FL_CNT_W-1:0] cnt);
        return cnt == FL_CNT_W'(FL_NUM_TAPS);
    endfunction

endpackage

// File: rtl/filter_loader.sv
// Streams one 3x3 filter from the weight memory into filter_buffer, one weight per accepted beat,
// holding off a reload while the convolver is still using the current weights.
module filter_loader
    import filter_loader_pkg::*;
#(
    parameter int WID_FILTER = FL_WID_FILTER
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_req,
    input  logic                  conv_busy,
    input  logic                  w_valid,
    input  logic [WID_FILTER-1:0] w_data,
    output logic                  w_ready,
    output logic                  shifting,
    output logic [WID_FILTER-1:0] inp,
    output logic                  weights_valid,
    output logic                  load_pending,
    output logic [FL_CNT_W-1:0]   tap_cnt
);

    fl_state_t             r_state;
    logic [FL_CNT_W-1:0]   r_tapCnt;
    logic                  r_shifting;
    logic [WID_FILTER-1:0] r_inp;
    logic                  r_weightsValid;
    logic                  r_loadPending;

    logic                  w_full;
    logic                  w_accept;

    assign w_full   = tapsFull(r_tapCnt);
    assign w_ready  = (r_state == FL_LOAD) && !w_full;
    assign w_accept = w_valid && w_ready;

    // The HOLD transition waits one cycle past the ninth accept so weights_valid
    // only rises once filter_buffer has registered the final shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= FL_IDLE;
            r_tapCnt       <= '0;
            r_shifting     <= 1'b0;
            r_inp          <= '0;
            r_weightsValid <= 1'b0;
            r_loadPending  <= 1'b0;
        end else begin
            r_shifting <= 1'b0;
            case (r_state)
                FL_IDLE, FL_HOLD: begin
                    if (load_req) begin
                        if (conv_busy) begin
                            r_state       <= FL_WAIT;
                            r_loadPending <= 1'b1;
                        end else begin
                            r_state        <= FL_LOAD;
                            r_tapCnt       <= '0;
                            r_weightsValid <= 1'b0;
                        end
                    end
                end
                FL_WAIT: begin
                    if (!conv_busy) begin
                        r_state        <= FL_LOAD;
                        r_loadPending  <= 1'b0;
                        r_tapCnt       <= '0;
                        r_weightsValid <= 1'b0;
                    end
                end
                FL_LOAD: begin
                    if (w_full) begin
                        r_state        <= FL_HOLD;
                        r_weightsValid <= 1'b1;
                    end else if (w_accept) begin
                        r_shifting <= 1'b1;
                        r_inp      <= w_data;
                        r_tapCnt   <= r_tapCnt + FL_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= FL_IDLE;
                end
            endcase
        end
    end

    assign shifting      = r_shifting;
    assign inp           = r_inp;
    assign weights_valid = r_weightsValid;
    assign load_pending  = r_loadPending;
    assign tap_cnt       = r_tapCnt;

endmodule
